alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Executes the normalized 8-bit ALU opcode produced by the ALU controller stage.
//  Register-file operands A/B come in over a valid/ready handshake; the result and PSR flags go out over a second valid/ready handshake.
//  Logic/add/compare/LUI complete in one cycle; LSH is an iterative 1-bit/cycle shifter; MUL is an iterative shift-add.
//  Sits between the controller/regfile read stage and writeback.
// PARAMETERS
//  WIDTH  16  datapath width (even, >=8); SHW = $clog2(WIDTH)+1 is the signed shift-amount width
// PORTS
//  clock      in   1      system clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      opcode/operands valid
//  in_ready   out  1      unit can accept an operation
//  aluOpcode  in   8      normalized opcode (table below)
//  a          in   WIDTH  operand A (Rdest)
//  b          in   WIDTH  operand B (Rsrc/immediate)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      writeback accepts result
//  result     out  WIDTH  result value
//  flags      out  5      {C,L,F,Z,N}
//  flags_we   out  1      flags updated by this op (qualifies flags)
//  illegal    out  1      opcode not supported
// BEHAVIOUR
//  One clock domain: clock. Reset is synchronous and active-high.
//  Opcodes:
//   - 0x01 AND, 0x02 OR, 0x03 XOR, 0x05 ADD, 0x06 ADDU, 0x09 SUB, 0x0B CMP, 0x0D MOV (result=b), 0x0E MUL (optional)
//   - 0x84 LSH: shamt = b[SHW-1:0] two's complement; >0 logical left, <0 logical right, 0 -> result=a
//   - 0xF0-0xFF LUI: result = {b[WIDTH/2-1:0], WIDTH/2 zeros}
//   - any other value -> illegal
//  Reset (also mid-operation) aborts any op:
//   - state IDLE; out_valid=0, result=0, flags=0, flags_we=0, illegal=0; in_ready=1 in the cycle after reset deasserts.
//  Handshakes:
//   - in_ready = (state==IDLE) && !out_valid. An op is accepted on an edge with in_valid && in_ready; aluOpcode/a/b are captured there.
//   - out_valid rises with result, flags, flags_we and illegal. All four hold stable until an edge with out_ready=1, then out_valid drops.
//   - No new op is accepted in the cycle out_valid drops; the earliest accept is the following edge.
//  FSM states IDLE, SHIFT, MUL, DONE:
//   - IDLE -> DONE for single-cycle ops: out_valid at accept edge +1.
//   - IDLE -> SHIFT for LSH with |shamt|>0: one bit per cycle, out_valid at accept +|shamt|+1. shamt=-2^(SHW-1) shifts fully out, so result=0.
//   - IDLE -> MUL: WIDTH iterations, out_valid at accept +WIDTH+1.
//   - DONE -> IDLE on out_ready.
//  Arithmetic/flags (flags_we=1 only for ADD, ADDU, SUB, CMP; otherwise flags_we=0 and flags hold their previous value):
//   - ADD/ADDU: result = a+b mod 2^WIDTH; C = carry-out; F = signed overflow; L, Z, N = 0.
//   - SUB: result = a-b mod 2^WIDTH; C = borrow; F = signed overflow.
//   - CMP: result = a (no writeback semantics); Z = (a==b); L = (a<b unsigned); N = (a<b signed); C, F = 0.
//   - MUL: result = low WIDTH bits of a*b (unsigned).
//  Illegal opcode: completes in 1 cycle (state DONE); result=0, illegal=1, flags_we=0.
//  in_valid while busy: ignored, no side effects; the upstream stage holds it.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - 0x0E runs the iterative multiplier; MUL state and its datapath are present.
//  ALU_MUL_EN undefined:
//   - no MUL state or logic; 0x0E is treated as illegal (1 cycle, result=0, illegal=1).
// TESTING
//  - reset held 2 cycles mid-SHIFT -> next cycle: out_valid=0, result=0, flags=0, in_ready=1
//  - ADD a=0x7FFF b=0x0001 -> 1 cycle later result=0x8000, F=1, C=0, flags_we=1; ADDU 0xFFFF+0x0001 -> result=0, C=1
//  - CMP a=0x0001 b=0xFFFF -> Z=0, L=1, N=0, result=0x0001
//  - LSH a=0x00F0 b=0x0004 -> out_valid at +5, result=0x0F00; b=0x1C (-4) -> result=0x000F at +5; b=0x10 -> result=0x0000 at +17
//  - MUL (ALU_MUL_EN) 0x0123*0x0010 -> result=0x1230 at +17; without the macro -> illegal=1 at +1
//  - out_ready held 0 for 5 cycles -> result/flags stable, in_ready=0; opcode 0x4C -> illegal=1, result=0

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Executes one normalized 8-bit ALU opcode per transaction. Operands arrive
// over an in_valid/in_ready handshake and are captured on the accept edge.
// The result and PSR flags leave over an out_valid/out_ready handshake.
// Logic, add/sub, compare, MOV and LUI finish in one cycle. LSH is an
// iterative shifter that moves one bit per cycle. MUL is an iterative
// shift-add multiplier that runs WIDTH cycles.
//
// Configuration macro: ALU_MUL_EN
//   defined   : opcode 0x0E runs the iterative multiplier (MUL state present)
//   undefined : no multiplier logic; 0x0E is reported as illegal
//
// Ports
//   clock      in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high; aborts any operation
//   in_valid   in   1      opcode/operands valid
//   in_ready   out  1      unit can accept an operation
//   aluOpcode  in   8      normalized opcode
//   a          in   WIDTH  operand A (Rdest)
//   b          in   WIDTH  operand B (Rsrc/immediate)
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      writeback accepts the result
//   result     out  WIDTH  result value
//   flags      out  5      {C,L,F,Z,N}
//   flags_we   out  1      flags were updated by this operation
//   illegal    out  1      opcode not supported
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       aluOpcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             flags_we,
    output logic             illegal
);

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_LSH  = 8'h84;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef ALU_MUL_EN
        S_MUL   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;
    logic             r_flags_we;
    logic             r_illegal;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;

    state_t           w_state_nx;
    logic             w_out_valid_nx;
    logic [WIDTH-1:0] w_result_nx;
    logic [4:0]       w_flags_nx;
    logic             w_flags_we_nx;
    logic             w_illegal_nx;
    logic [SHW-1:0]   w_cnt_nx;
    logic             w_left_nx;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_mcand_nx;
    logic [WIDTH-1:0] w_mplier_nx;
`endif

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [SHW-1:0]   w_shamt;
    logic [SHW-1:0]   w_shmag;

    assign in_ready  = (r_state == S_IDLE) && !r_out_valid;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign flags_we  = r_flags_we;
    assign illegal   = r_illegal;

    // Extra top bit carries the carry-out (add) or borrow (sub).
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    // Signed shift amount; the magnitude of -2^(SHW-1) still fits as an
    // unsigned SHW-bit count, so a full shift-out needs no special case.
    assign w_shamt   = b[SHW-1:0];
    assign w_shmag   = w_shamt[SHW-1] ? -w_shamt : w_shamt;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nx     = r_state;
        w_out_valid_nx = r_out_valid;
        w_result_nx    = r_result;
        w_flags_nx     = r_flags;
        w_flags_we_nx  = r_flags_we;
        w_illegal_nx   = r_illegal;
        w_cnt_nx       = r_cnt;
        w_left_nx      = r_left;
`ifdef ALU_MUL_EN
        w_mcand_nx     = r_mcand;
        w_mplier_nx    = r_mplier;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Most opcodes complete immediately; those that iterate
                    // override the state and clear out_valid below.
                    w_state_nx     = S_DONE;
                    w_out_valid_nx = 1'b1;
                    w_flags_we_nx  = 1'b0;
                    w_illegal_nx   = 1'b0;
                    case (aluOpcode)
                        OP_AND: w_result_nx = a & b;
                        OP_OR:  w_result_nx = a | b;
                        OP_XOR: w_result_nx = a ^ b;
                        OP_MOV: w_result_nx = b;
                        OP_ADD, OP_ADDU: begin
                            w_result_nx   = w_sum[WIDTH-1:0];
                            w_flags_nx    = {w_sum[WIDTH], 1'b0, w_add_ovf, 1'b0, 1'b0};
                            w_flags_we_nx = 1'b1;
                        end
                        OP_SUB: begin
                            w_result_nx   = w_diff[WIDTH-1:0];
                            w_flags_nx    = {w_diff[WIDTH], 1'b0, w_sub_ovf, 1'b0, 1'b0};
                            w_flags_we_nx = 1'b1;
                        end
                        OP_CMP: begin
                            w_result_nx   = a;
                            w_flags_nx    = {1'b0, (a < b), 1'b0, (a == b),
                                             ($signed(a) < $signed(b))};
                            w_flags_we_nx = 1'b1;
                        end
                        OP_LSH: begin
                            w_result_nx = a;
                            if (w_shmag != '0) begin
                                w_state_nx     = S_SHIFT;
                                w_out_valid_nx = 1'b0;
                                w_cnt_nx       = w_shmag;
                                w_left_nx      = !w_shamt[SHW-1];
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            w_state_nx     = S_MUL;
                            w_out_valid_nx = 1'b0;
                            w_result_nx    = '0;
                            w_mcand_nx     = a;
                            w_mplier_nx    = b;
                            w_cnt_nx       = SHW'(WIDTH);
                        end
`endif
                        default: begin
                            if (aluOpcode[7:4] == 4'hF) begin
                                w_result_nx = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                            end else begin
                                w_result_nx  = '0;
                                w_illegal_nx = 1'b1;
                            end
                        end
                    endcase
                end
            end

            S_SHIFT: begin
                w_result_nx = r_left ? (r_result << 1) : (r_result >> 1);
                w_cnt_nx    = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_state_nx     = S_DONE;
                    w_out_valid_nx = 1'b1;
                end
            end

`ifdef ALU_MUL_EN
            S_MUL: begin
                // Low WIDTH bits only: partial products shifted past the top
                // are discarded along with the multiplicand's high bits.
                if (r_mplier[0]) begin
                    w_result_nx = r_result + r_mcand;
                end
                w_mcand_nx  = r_mcand << 1;
                w_mplier_nx = r_mplier >> 1;
                w_cnt_nx    = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_state_nx     = S_DONE;
                    w_out_valid_nx = 1'b1;
                end
            end
`endif

            S_DONE: begin
                if (out_ready) begin
                    w_state_nx     = S_IDLE;
                    w_out_valid_nx = 1'b0;
                end
            end

            default: begin
                w_state_nx     = S_IDLE;
                w_out_valid_nx = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: only the visible outputs and the state need a defined
            // reset value; the shift/multiply work registers are always
            // reloaded at accept before they are read.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_flags_we  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_out_valid <= w_out_valid_nx;
            r_result    <= w_result_nx;
            r_flags     <= w_flags_nx;
            r_flags_we  <= w_flags_we_nx;
            r_illegal   <= w_illegal_nx;
        end
    end

    always_ff @(posedge clock) begin
        r_cnt    <= w_cnt_nx;
        r_left   <= w_left_nx;
`ifdef ALU_MUL_EN
        r_mcand  <= w_mcand_nx;
        r_mplier <= w_mplier_nx;
`endif
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed-vector bench for alu_exec_unit (WIDTH=16). The driver issues each
// operation and pushes the hand-computed response, including the expected
// latency measured from the cycle the operation is accepted, into a queue. A
// separate monitor pops and compares whenever the unit raises out_valid.
// Define ALU_MUL_EN for both bench and RTL to exercise the multiplier.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       aluOpcode = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;
    logic             flags_we;
    logic             illegal;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluOpcode (aluOpcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .flags_we  (flags_we),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] res;
        logic [4:0]       flg;
        logic             we;
        logic             ill;
        int               lat;
        bit               stall;
        int               acc;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] last_flags = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Flags {C,L,F,Z,N}. Ops that do not write flags expect the previous value.
    task automatic issue(input string name, input logic [7:0] op,
                         input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [WIDTH-1:0] res, input logic we, input logic [4:0] flg,
                         input logic ill, input int lat, input bit stall);
        exp_t e;
        int   w;
        aluOpcode = op;
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        w         = 0;
        while (!in_ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            fail_now({name, " accept"});
            in_valid = 1'b0;
            return;
        end
        e.name  = name;
        e.res   = res;
        e.we    = we;
        e.flg   = we ? flg : last_flags;
        e.ill   = ill;
        e.lat   = lat;
        e.stall = stall;
        e.acc   = cyc;
        if (we) last_flags = flg;
        sb.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (sb.size() != 0 || out_valid) fail_now({name, " drain"});
    endtask

    // Monitor: compares every response against the head of the scoreboard.
    initial begin : monitor
        exp_t             e;
        bit               seen;
        logic [WIDTH-1:0] h_res;
        logic [4:0]       h_flg;
        seen = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    fail_now("unexpected out_valid");
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"},  result,    e.res);
                    check({e.name, " flags"},   flags,     e.flg);
                    check({e.name, " flags_we"}, flags_we, e.we);
                    check({e.name, " illegal"}, illegal,   e.ill);
                    check({e.name, " latency"}, cyc - e.acc, e.lat);
                    if (e.stall) begin
                        out_ready = 1'b0;
                        h_res = result;
                        h_flg = flags;
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clock);
                            check({e.name, " stall out_valid"}, out_valid, 1'b1);
                            check({e.name, " stall in_ready"},  in_ready,  1'b0);
                            check({e.name, " stall result"},    result,    h_res);
                            check({e.name, " stall flags"},     flags,     h_flg);
                            check({e.name, " stall illegal"},   illegal,   e.ill);
                        end
                        out_ready = 1'b1;
                    end
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset out_valid", out_valid, 1'b0);
        check("reset result",    result,    16'h0000);
        check("reset flags",     flags,     5'b00000);
        check("reset flags_we",  flags_we,  1'b0);
        check("reset illegal",   illegal,   1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("post-reset in_ready", in_ready, 1'b1);

        // Signed overflow on ADD leaves nonzero flags before the reset test.
        issue("ADD ovf", 8'h05, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 5'b00100, 1'b0, 1, 1'b0);
        drain("ADD ovf");

        // Reset held 2 cycles in the middle of a 16-step shift.
        aluOpcode = 8'h84;
        a         = 16'h00F0;
        b         = 16'h0010;
        in_valid  = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid-shift in_ready", in_ready, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        last_flags = 5'b00000;
        @(negedge clock);
        check("abort out_valid", out_valid, 1'b0);
        check("abort result",    result,    16'h0000);
        check("abort flags",     flags,     5'b00000);
        check("abort in_ready",  in_ready,  1'b1);

        // Arithmetic and compare
        issue("ADDU carry", 8'h06, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5'b10000, 1'b0, 1, 1'b0);
        issue("CMP",        8'h0B, 16'h0001, 16'hFFFF, 16'h0001, 1'b1, 5'b01000, 1'b0, 1, 1'b0);
        issue("CMP equal",  8'h0B, 16'h8000, 16'h8000, 16'h8000, 1'b1, 5'b00010, 1'b0, 1, 1'b0);
        issue("CMP signed", 8'h0B, 16'h8000, 16'h0001, 16'h8000, 1'b1, 5'b00001, 1'b0, 1, 1'b0);
        issue("SUB borrow", 8'h09, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 5'b10000, 1'b0, 1, 1'b0);
        issue("SUB ovf",    8'h09, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 5'b00100, 1'b0, 1, 1'b0);

        // Logic ops and MOV keep the previous flags
        issue("AND", 8'h01, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 5'b00000, 1'b0, 1, 1'b0);
        issue("OR",  8'h02, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 5'b00000, 1'b0, 1, 1'b0);
        issue("XOR", 8'h03, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 5'b00000, 1'b0, 1, 1'b0);
        issue("MOV", 8'h0D, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b0, 5'b00000, 1'b0, 1, 1'b0);

        // Shifter
        issue("LSH +4",   8'h84, 16'h00F0, 16'h0004, 16'h0F00, 1'b0, 5'b00000, 1'b0, 5,  1'b0);
        issue("LSH -4",   8'h84, 16'h00F0, 16'h001C, 16'h000F, 1'b0, 5'b00000, 1'b0, 5,  1'b0);
        issue("LSH -16",  8'h84, 16'h00F0, 16'h0010, 16'h0000, 1'b0, 5'b00000, 1'b0, 17, 1'b0);
        issue("LSH 0",    8'h84, 16'h00F0, 16'h0000, 16'h00F0, 1'b0, 5'b00000, 1'b0, 1,  1'b0);
        issue("LSH +1 hi", 8'h84, 16'h80F0, 16'hFFE1, 16'h01E0, 1'b0, 5'b00000, 1'b0, 2, 1'b0);

        // LUI range
        issue("LUI F5", 8'hF5, 16'h5555, 16'h12AB, 16'hAB00, 1'b0, 5'b00000, 1'b0, 1, 1'b0);
        issue("LUI F0", 8'hF0, 16'h0000, 16'hFFFF, 16'hFF00, 1'b0, 5'b00000, 1'b0, 1, 1'b0);

        // Multiplier (optional)
`ifdef ALU_MUL_EN
        issue("MUL",      8'h0E, 16'h0123, 16'h0010, 16'h1230, 1'b0, 5'b00000, 1'b0, 17, 1'b0);
        issue("MUL wrap", 8'h0E, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 5'b00000, 1'b0, 17, 1'b0);
`else
        issue("MUL off",  8'h0E, 16'h0123, 16'h0010, 16'h0000, 1'b0, 5'b00000, 1'b1, 1, 1'b0);
`endif

        // Illegal opcodes, one with writeback back-pressure
        issue("ILL 4C stall", 8'h4C, 16'h1111, 16'h2222, 16'h0000, 1'b0, 5'b00000, 1'b1, 1, 1'b1);
        issue("ILL 00",       8'h00, 16'h1111, 16'h2222, 16'h0000, 1'b0, 5'b00000, 1'b1, 1, 1'b0);
        issue("ADD after",    8'h05, 16'h0001, 16'h0001, 16'h0002, 1'b1, 5'b00000, 1'b0, 1, 1'b0);

        drain("final");
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
